// File: rtl/rx_udp_buf_ctrl_pkg.sv
// Shared encodings for the receive-side UDP buffer controller.
//   bank_st_e : per-bank occupancy state (empty / being written / committed)
//   wr_st_e   : write-side FSM states
//   sat_inc   : saturating increment for 16-bit event counters
package rx_udp_buf_ctrl_pkg;

   typedef enum logic [1:0] {
      BankEmpty   = 2'b00,
      BankFilling = 2'b01,
      BankFull    = 2'b10
   } bank_st_e;

   typedef enum logic [1:0] {
      WIdle = 2'b00,
      WFill = 2'b01,
      WDrop = 2'b10
   } wr_st_e;

   localparam int unsigned DropCntW = 16;

   function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
      return (&v) ? v : v + DropCntW'(1);
   endfunction

endpackage

// File: rtl/rx_udp_bank_ram.sv
// Two-bank payload RAM: one write port, one registered read port, single clock.
// Addressed as {bank, offset}; kept separate so it can be swapped for a macro.
//   clk_i   : clock
//   rst_ni  : async active-low reset (read register only)
//   we_i    : write enable, waddr_i/wdata_i : write address/data
//   re_i    : read enable, raddr_i : read address
//   rdata_o : read data, one cycle after re_i; holds when re_i is low
module rx_udp_bank_ram #(
   parameter int unsigned OCT = 8,
   parameter int unsigned AW  = 9
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           we_i,
   input  logic [AW:0]    waddr_i,
   input  logic [OCT-1:0] wdata_i,
   input  logic           re_i,
   input  logic [AW:0]    raddr_i,
   output logic [OCT-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** (AW + 1);

   logic [OCT-1:0] mem_q [Depth];
   logic [OCT-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_udp_buf_ctrl.sv
// Receive buffer controller behind the UDP receive stage. Writes each datagram
// into one bank of a ping-pong payload RAM, commits it with length/source port,
// pulses an interrupt, and presents the oldest committed frame to a reader.
//   RX_CLK, rst_n   : clock, async active-low reset
//   func_en         : block enable; low aborts a frame being written
//   rx_udp_data_v/rx_udp_data/rx_src_port : payload stream and its source port
//   rd_en/rd_addr/rd_data : byte read of the ready frame, one-cycle latency
//   rd_release      : frees the ready bank
//   rdy/rdy_len/rdy_src_port/rdy_trunc : ready-frame status and metadata
//   rx_buf_irq      : one-cycle pulse per commit
//   drop_cnt        : saturating count of frames dropped for lack of a bank
module rx_udp_buf_ctrl #(
   parameter int unsigned OCT    = 8,
   parameter int unsigned BUF_AW = 9
) (
   input  logic              RX_CLK,
   input  logic              rst_n,
   input  logic              func_en,
   input  logic              rx_udp_data_v,
   input  logic [OCT-1:0]    rx_udp_data,
   input  logic [2*OCT-1:0]  rx_src_port,
   input  logic              rd_en,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [OCT-1:0]    rd_data,
   input  logic              rd_release,
   output logic              rdy,
   output logic [BUF_AW:0]   rdy_len,
   output logic [2*OCT-1:0]  rdy_src_port,
   output logic              rdy_trunc,
   output logic              rx_buf_irq,
   output logic [15:0]       drop_cnt
);

   import rx_udp_buf_ctrl_pkg::*;

   localparam int unsigned PtrW = BUF_AW + 1;
   localparam int unsigned SrcW = 2 * OCT;

   bank_st_e            bank_st_q [2];
   bank_st_e            bank_st_d [2];
   logic [PtrW-1:0]     len_q [2];
   logic [PtrW-1:0]     len_d [2];
   logic [SrcW-1:0]     src_q [2];
   logic [SrcW-1:0]     src_d [2];
   logic [1:0]          trunc_q, trunc_d;

   wr_st_e              wr_st_q, wr_st_d;
   logic                wr_bank_q, wr_bank_d;
   logic                rd_bank_q, rd_bank_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic                irq_q, irq_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;

   logic                ram_we;
   logic [BUF_AW:0]     ram_waddr;
   logic                rdy_int;
   logic                rd_fire;

   assign rdy_int = (bank_st_q[rd_bank_q] == BankFull);
   assign rd_fire = rd_en && rdy_int;

   always_comb begin
      bank_st_d  = bank_st_q;
      len_d      = len_q;
      src_d      = src_q;
      trunc_d    = trunc_q;
      wr_st_d    = wr_st_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_ptr_d   = wr_ptr_q;
      irq_d      = 1'b0;
      drop_cnt_d = drop_cnt_q;
      ram_we     = 1'b0;
      ram_waddr  = {wr_bank_q, wr_ptr_q[BUF_AW-1:0]};

      if (!func_en) begin
         // Abort an in-flight frame; committed banks are left alone.
         wr_st_d = WIdle;
         if (bank_st_q[wr_bank_q] == BankFilling) begin
            bank_st_d[wr_bank_q] = BankEmpty;
         end
      end else begin
         unique case (wr_st_q)
            WIdle: begin
               if (rx_udp_data_v) begin
                  // Admission uses registered bank state, so a same-cycle
                  // release cannot rescue this frame.
                  if (bank_st_q[wr_bank_q] == BankEmpty) begin
                     ram_we               = 1'b1;
                     ram_waddr            = {wr_bank_q, {BUF_AW{1'b0}}};
                     wr_ptr_d             = PtrW'(1);
                     src_d[wr_bank_q]     = rx_src_port;
                     trunc_d[wr_bank_q]   = 1'b0;
                     bank_st_d[wr_bank_q] = BankFilling;
                     wr_st_d              = WFill;
                  end else begin
                     drop_cnt_d = sat_inc(drop_cnt_q);
                     wr_st_d    = WDrop;
                  end
               end
            end
            WFill: begin
               if (rx_udp_data_v) begin
                  // MSB of the pointer set means the bank is already full.
                  if (!wr_ptr_q[BUF_AW]) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PtrW'(1);
                  end else begin
                     trunc_d[wr_bank_q] = 1'b1;
                  end
               end else begin
                  len_d[wr_bank_q]     = wr_ptr_q;
                  bank_st_d[wr_bank_q] = BankFull;
                  irq_d                = 1'b1;
                  wr_bank_d            = ~wr_bank_q;
                  wr_st_d              = WIdle;
               end
            end
            WDrop: begin
               if (!rx_udp_data_v) begin
                  wr_st_d = WIdle;
               end
            end
            default: wr_st_d = WIdle;
         endcase
      end

      // The ready bank is FULL, so it never collides with the bank being written.
      if (rd_release && rdy_int) begin
         bank_st_d[rd_bank_q] = BankEmpty;
         rd_bank_d            = ~rd_bank_q;
      end
   end

   always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            bank_st_q[i] <= BankEmpty;
            len_q[i]     <= '0;
            src_q[i]     <= '0;
         end
         trunc_q    <= '0;
         wr_st_q    <= WIdle;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         irq_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         bank_st_q  <= bank_st_d;
         len_q      <= len_d;
         src_q      <= src_d;
         trunc_q    <= trunc_d;
         wr_st_q    <= wr_st_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         irq_q      <= irq_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   rx_udp_bank_ram #(
      .OCT (OCT),
      .AW  (BUF_AW)
   ) u_ram (
      .clk_i   (RX_CLK),
      .rst_ni  (rst_n),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (rx_udp_data),
      .re_i    (rd_fire),
      .raddr_i ({rd_bank_q, rd_addr}),
      .rdata_o (rd_data)
   );

   assign rdy          = rdy_int;
   assign rdy_len      = len_q[rd_bank_q];
   assign rdy_src_port = src_q[rd_bank_q];
   assign rdy_trunc    = trunc_q[rd_bank_q];
   assign rx_buf_irq   = irq_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_rx_udp_buf_ctrl.sv
// Directed bench for rx_udp_buf_ctrl: a per-cycle vector table for a single
// frame plus hand-written sequences for drop, truncation, abort, release
// collision and asynchronous reset.
module tb_rx_udp_buf_ctrl;

   logic        RX_CLK = 1'b0;
   logic        rst_n;
   logic        func_en;
   logic        rx_udp_data_v;
   logic [7:0]  rx_udp_data;
   logic [15:0] rx_src_port;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        rd_release;
   logic        rdy;
   logic [9:0]  rdy_len;
   logic [15:0] rdy_src_port;
   logic        rdy_trunc;
   logic        rx_buf_irq;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 RX_CLK = ~RX_CLK;

   rx_udp_buf_ctrl #(
      .OCT    (8),
      .BUF_AW (9)
   ) dut (
      .RX_CLK        (RX_CLK),
      .rst_n         (rst_n),
      .func_en       (func_en),
      .rx_udp_data_v (rx_udp_data_v),
      .rx_udp_data   (rx_udp_data),
      .rx_src_port   (rx_src_port),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_release    (rd_release),
      .rdy           (rdy),
      .rdy_len       (rdy_len),
      .rdy_src_port  (rdy_src_port),
      .rdy_trunc     (rdy_trunc),
      .rx_buf_irq    (rx_buf_irq),
      .drop_cnt      (drop_cnt)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       rd_en;
      logic [8:0] addr;
      logic       rel;
      logic       exp_rdy;
      logic [9:0] exp_len;
      logic [15:0] exp_port;
      logic       exp_trunc;
      logic       exp_irq;
      logic       chk_rd;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic v, input logic [7:0] d, input logic re,
                          input logic [8:0] addr, input logic rel, input logic e_rdy,
                          input logic [9:0] e_len, input logic [15:0] e_port,
                          input logic e_trunc, input logic e_irq, input logic c_rd,
                          input logic [7:0] e_rd);
      vec_t r;
      r.v = v; r.d = d; r.rd_en = re; r.addr = addr; r.rel = rel;
      r.exp_rdy = e_rdy; r.exp_len = e_len; r.exp_port = e_port; r.exp_trunc = e_trunc;
      r.exp_irq = e_irq; r.chk_rd = c_rd; r.exp_rd = e_rd;
      vecs.push_back(r);
   endtask

   task automatic idle_inputs();
      rx_udp_data_v = 1'b0;
      rx_udp_data   = 8'h00;
      rd_en         = 1'b0;
      rd_addr       = '0;
      rd_release    = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " rdy"}, 32'(rdy), 32'd0);
      chk({tag, " rdy_len"}, 32'(rdy_len), 32'd0);
      chk({tag, " rdy_src_port"}, 32'(rdy_src_port), 32'd0);
      chk({tag, " rdy_trunc"}, 32'(rdy_trunc), 32'd0);
      chk({tag, " irq"}, 32'(rx_buf_irq), 32'd0);
      chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
      chk({tag, " rd_data"}, 32'(rd_data), 32'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      func_en = 1'b1;
      @(negedge RX_CLK);
      rst_n = 1'b0;
      repeat (2) @(negedge RX_CLK);
      rst_n = 1'b1;
   endtask

   // Bytes past the bank capacity are a fixed marker so a wrapped write shows.
   task automatic send_frame(input int n, input logic [7:0] base, input logic [15:0] port,
                             input logic rel_last, input logic exp_irq, input string tag);
      for (int i = 0; i < n; i++) begin
         rx_udp_data_v = 1'b1;
         rx_udp_data   = (i < 512) ? base + 8'(i) : 8'hEE;
         rx_src_port   = port;
         @(negedge RX_CLK);
      end
      rx_udp_data_v = 1'b0;
      rd_release    = rel_last;
      @(negedge RX_CLK);
      rd_release = 1'b0;
      chk({tag, " irq"}, 32'(rx_buf_irq), 32'(exp_irq));
      @(negedge RX_CLK);
      chk({tag, " irq one cycle"}, 32'(rx_buf_irq), 32'd0);
   endtask

   task automatic rd_check(input logic [8:0] addr, input logic [7:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = addr;
      @(negedge RX_CLK);
      rd_en = 1'b0;
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic pulse_release();
      rd_release = 1'b1;
      @(negedge RX_CLK);
      rd_release = 1'b0;
   endtask

   task automatic check_ready(input logic [9:0] len, input logic [15:0] port,
                              input logic trunc, input string tag);
      chk({tag, " rdy"}, 32'(rdy), 32'd1);
      chk({tag, " len"}, 32'(rdy_len), 32'(len));
      chk({tag, " port"}, 32'(rdy_src_port), 32'(port));
      chk({tag, " trunc"}, 32'(rdy_trunc), 32'(trunc));
   endtask

   initial begin
      rst_n       = 1'b0;
      func_en     = 1'b1;
      rx_src_port = 16'h0000;
      idle_inputs();

      // Single 5-byte frame, per-cycle expectations.
      add_vec(1, 8'h11, 0, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 8'h00);
      add_vec(1, 8'h12, 0, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 8'h00);
      add_vec(1, 8'h13, 0, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 8'h00);
      add_vec(1, 8'h14, 0, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 8'h00);
      add_vec(1, 8'h15, 0, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 8'h00);
      add_vec(0, 8'h00, 0, 9'd0, 0, 1, 10'd5, 16'h1234, 0, 1, 0, 8'h00);
      add_vec(0, 8'h00, 0, 9'd0, 0, 1, 10'd5, 16'h1234, 0, 0, 0, 8'h00);
      add_vec(0, 8'h00, 1, 9'd0, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h11);
      add_vec(0, 8'h00, 1, 9'd1, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h12);
      add_vec(0, 8'h00, 1, 9'd2, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h13);
      add_vec(0, 8'h00, 1, 9'd3, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h14);
      add_vec(0, 8'h00, 1, 9'd4, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h15);
      add_vec(0, 8'h00, 0, 9'd3, 0, 1, 10'd5, 16'h1234, 0, 0, 1, 8'h15);
      add_vec(0, 8'h00, 0, 9'd0, 1, 0, 10'd0, 16'h0, 0, 0, 1, 8'h15);
      add_vec(0, 8'h00, 1, 9'd0, 0, 0, 10'd0, 16'h0, 0, 0, 1, 8'h15);

      // Reset state while reset is held.
      #1;
      check_zero("reset");
      repeat (2) @(negedge RX_CLK);
      rst_n = 1'b1;
      check_zero("after reset");

      rx_src_port = 16'h1234;
      foreach (vecs[k]) begin
         rx_udp_data_v = vecs[k].v;
         rx_udp_data   = vecs[k].d;
         rd_en         = vecs[k].rd_en;
         rd_addr       = vecs[k].addr;
         rd_release    = vecs[k].rel;
         @(negedge RX_CLK);
         chk($sformatf("vec%0d rdy", k), 32'(rdy), 32'(vecs[k].exp_rdy));
         chk($sformatf("vec%0d irq", k), 32'(rx_buf_irq), 32'(vecs[k].exp_irq));
         if (vecs[k].exp_rdy) begin
            chk($sformatf("vec%0d len", k), 32'(rdy_len), 32'(vecs[k].exp_len));
            chk($sformatf("vec%0d port", k), 32'(rdy_src_port), 32'(vecs[k].exp_port));
            chk($sformatf("vec%0d trunc", k), 32'(rdy_trunc), 32'(vecs[k].exp_trunc));
         end
         if (vecs[k].chk_rd) begin
            chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vecs[k].exp_rd));
         end
      end
      idle_inputs();

      // Three frames, no release: third is dropped.
      do_reset();
      send_frame(4, 8'hA0, 16'h0A0A, 1'b0, 1'b1, "bb frame1");
      send_frame(4, 8'hB0, 16'h0B0B, 1'b0, 1'b1, "bb frame2");
      send_frame(4, 8'hC0, 16'h0C0C, 1'b0, 1'b0, "bb frame3");
      chk("bb drop_cnt", 32'(drop_cnt), 32'd1);
      check_ready(10'd4, 16'h0A0A, 1'b0, "bb first");
      rd_check(9'd3, 8'hA3, "bb rd frame1");
      pulse_release();
      check_ready(10'd4, 16'h0B0B, 1'b0, "bb second");
      rd_check(9'd0, 8'hB0, "bb rd frame2");

      // Oversized frame truncates at bank capacity.
      do_reset();
      send_frame(515, 8'h00, 16'hBEEF, 1'b0, 1'b1, "trunc");
      check_ready(10'd512, 16'hBEEF, 1'b1, "trunc");
      rd_check(9'd511, 8'hFF, "trunc rd 511");
      rd_check(9'd0, 8'h00, "trunc rd 0");
      rd_check(9'd300, 8'h2C, "trunc rd 300");

      // func_en drop mid-frame aborts it; next frame uses bank 0.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rx_udp_data_v = 1'b1;
         rx_udp_data   = 8'h30 + 8'(i);
         rx_src_port   = 16'h3333;
         @(negedge RX_CLK);
      end
      func_en       = 1'b0;
      rx_udp_data_v = 1'b0;
      @(negedge RX_CLK);
      chk("abort irq", 32'(rx_buf_irq), 32'd0);
      chk("abort rdy", 32'(rdy), 32'd0);
      func_en = 1'b1;
      @(negedge RX_CLK);
      chk("abort irq later", 32'(rx_buf_irq), 32'd0);
      chk("abort rdy later", 32'(rdy), 32'd0);
      send_frame(4, 8'h40, 16'h4444, 1'b0, 1'b1, "post-abort");
      check_ready(10'd4, 16'h4444, 1'b0, "post-abort");
      rd_check(9'd0, 8'h40, "post-abort rd");
      chk("abort drop_cnt", 32'(drop_cnt), 32'd0);

      // Release in the commit cycle of the second frame.
      do_reset();
      send_frame(4, 8'h50, 16'h5151, 1'b0, 1'b1, "coll frame1");
      send_frame(3, 8'h60, 16'h6262, 1'b1, 1'b1, "coll frame2");
      check_ready(10'd3, 16'h6262, 1'b0, "coll");
      rd_check(9'd2, 8'h62, "coll rd");
      pulse_release();
      chk("coll rdy cleared", 32'(rdy), 32'd0);

      // Asynchronous reset mid-frame and mid-read.
      do_reset();
      send_frame(4, 8'h70, 16'h7777, 1'b0, 1'b1, "ar frame1");
      rd_en         = 1'b1;
      rd_addr       = 9'd1;
      rx_udp_data_v = 1'b1;
      rx_udp_data   = 8'h90;
      rx_src_port   = 16'h9999;
      @(negedge RX_CLK);
      chk("ar rd before reset", 32'(rd_data), 32'h71);
      rx_udp_data = 8'h91;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async reset");
      idle_inputs();
      @(negedge RX_CLK);
      @(negedge RX_CLK);
      rst_n = 1'b1;
      send_frame(2, 8'h80, 16'h8888, 1'b0, 1'b1, "ar fresh");
      check_ready(10'd2, 16'h8888, 1'b0, "ar fresh");
      rd_check(9'd1, 8'h81, "ar fresh rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_udp_buf_ctrl.md
Name: rx_udp_buf_ctrl

Overview:
- Receive-side buffer controller behind the UDP receive stage.
- Takes the registered UDP payload stream (valid/data plus latched source port) and writes each datagram into one bank of a two-bank ping-pong payload RAM.
- Commits each completed frame with its length and source port, raises a one-cycle interrupt, and exposes the oldest committed frame to a byte-addressed reader, which frees the bank with a release pulse.
- Drops frames when no bank is free and counts the drops.

Parameters:
- OCT, 8, byte width.
- BUF_AW, 9, per-bank address width; bank capacity is 2^BUF_AW bytes.

Ports:
- RX_CLK  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- func_en  input  1  block enable; low aborts any frame being written.
- rx_udp_data_v  input  1  payload byte valid; high for the whole frame, contiguous.
- rx_udp_data  input  OCT  payload byte.
- rx_src_port  input  2*OCT  UDP source port; stable while rx_udp_data_v is high.
- rd_en  input  1  read strobe.
- rd_addr  input  BUF_AW  byte offset within the ready frame.
- rd_data  output  OCT  read data, one-cycle latency.
- release  input  1  pulse; frees the ready bank.
- rdy  output  1  a committed frame is available.
- rdy_len  output  BUF_AW+1  byte count of the ready frame.
- rdy_src_port  output  2*OCT  source port of the ready frame.
- rdy_trunc  output  1  ready frame exceeded capacity and was truncated.
- rx_buf_irq  output  1  one-cycle pulse on each commit.
- drop_cnt  output  16  dropped-frame count; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync deassert): both banks EMPTY; wr_bank=0; rd_bank=0; write FSM in W_IDLE.
  - Outputs: rdy=0, rdy_len=0, rdy_src_port=0, rdy_trunc=0, rx_buf_irq=0, drop_cnt=0, rd_data=0.
- Per-bank state: EMPTY, FILLING, FULL. Per-bank metadata: len (BUF_AW+1 bits), src_port, trunc.
- Write FSM:
  - W_IDLE, on rx_udp_data_v=1:
    - If bank[wr_bank]==EMPTY: write the byte at address 0, set wr_ptr=1, latch src_port from rx_src_port, clear trunc, bank becomes FILLING, go to W_FILL.
    - Otherwise: drop_cnt increments (saturating), go to W_DROP.
  - W_FILL, on rx_udp_data_v=1:
    - If wr_ptr < 2^BUF_AW: write the byte at wr_ptr, wr_ptr increments.
    - Otherwise: discard the byte, set trunc.
  - W_FILL, on rx_udp_data_v=0: commit.
    - len=wr_ptr; bank becomes FULL; rx_buf_irq=1 on the next cycle; wr_bank toggles; go to W_IDLE.
  - W_DROP: remain until rx_udp_data_v=0, then go to W_IDLE. Nothing is written.
- func_en=0:
  - Write FSM forced to W_IDLE.
  - A FILLING bank returns to EMPTY; no irq, no drop count.
  - FULL banks and the read side are unaffected.
  - A frame already in progress when func_en rises is treated as new at its next valid byte. The bench must not rely on this case.
- Read side:
  - rdy = (bank[rd_bank]==FULL).
  - rdy_len, rdy_src_port, rdy_trunc are combinational views of bank[rd_bank] metadata.
  - rd_en with rdy=1: rd_data = RAM[rd_bank][rd_addr] on the next cycle.
  - rd_en with rdy=0: rd_data holds its previous value.
  - release with rdy=1: bank[rd_bank] becomes EMPTY and rd_bank toggles.
  - release with rdy=0: ignored.
- Simultaneous events:
  - Commit and release in the same cycle: both take effect.
  - A release that frees bank[wr_bank] in the same cycle as a frame start does not admit that frame; the frame is dropped. Admission is based on the registered state.
- Ordering: frames are delivered strictly in arrival order; rd_bank always points at the older FULL bank.
- Truncated frames: len = 2^BUF_AW, trunc=1.

Decomposition:
- Shared package (MAC-wide): bank state encodings (EMPTY=2'b00, FILLING=2'b01, FULL=2'b10) and write FSM encodings (W_IDLE, W_FILL, W_DROP).
- One sub-module, rx_udp_bank_ram:
  - Simple dual-port RAM of 2*2^BUF_AW x OCT, addressed as {bank, addr}.
  - One write port, one registered read port, same clock.
  - Separable so it can map to a hard macro.

Test Plan:
- Single frame of 5 bytes 0x11..0x15 from src_port 0x1234 -> rx_buf_irq pulses once, 1 cycle after data_v falls; rdy=1, rdy_len=5, rdy_src_port=0x1234, rdy_trunc=0; reads at addr 0..4 return 0x11..0x15 with 1-cycle latency; release -> rdy=0.
- Three back-to-back 4-byte frames with no release -> first two commit; third gives drop_cnt=1 and no irq; release -> rdy shows frame 2's length and port.
- Frame of 2^BUF_AW+3 bytes (515) -> rdy_len=512, rdy_trunc=1, last stored byte is byte 511.
- func_en deasserted after 3 bytes of a frame -> no irq, bank EMPTY, rdy stays 0; next frame lands in bank 0 and commits normally.
- Release asserted in the commit cycle of the second frame while the first is ready -> rdy remains 1 and shows frame 2; a subsequent release clears rdy.
- rst_n asserted mid-frame and mid-read -> all outputs immediately 0; a fresh frame after deassert lands in bank 0.
